// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and ASCII constants for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CLASSIFY,
    EXEC,
    SEND,
    GAP,
    ECHO
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_L  = 8'h4C;
  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_O  = 8'h4F;
  localparam logic [7:0] CHAR_K  = 8'h4B;
  localparam logic [7:0] CHAR_E  = 8'h45;

  // Replies are at most four bytes, so three bits covers 0..4.
  typedef logic [2:0] reply_len_t;

endpackage

// File: rtl/uart_cmd_parser_hex_codec.sv
// Combinational ASCII-hex <-> nibble converter used by both the command
// decoder and the read-back reply path.
module hex_codec (
  input  logic [7:0] ascii_in,
  output logic [3:0] nibble_out,
  output logic       nibble_valid,
  input  logic [3:0] nibble_in,
  output logic [7:0] ascii_out
);

  always_comb begin
    nibble_out   = 4'h0;
    nibble_valid = 1'b0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      nibble_out   = 4'(ascii_in - 8'h30);
      nibble_valid = 1'b1;
    end else if (ascii_in >= 8'h41 && ascii_in <= 8'h46) begin
      nibble_out   = 4'(ascii_in - 8'h37);
      nibble_valid = 1'b1;
    end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
      nibble_out   = 4'(ascii_in - 8'h57);
      nibble_valid = 1'b1;
    end
  end

  // Encoding is always uppercase.
  assign ascii_out = (nibble_in < 4'd10) ? (8'h30 + {4'h0, nibble_in})
                                         : (8'h37 + {4'h0, nibble_in});

endmodule

// File: rtl/uart_cmd_parser.sv
// Line-oriented command parser between the UART RX and TX FIFOs (L<hex>, R).
// Define UART_CMD_ECHO_EN to echo each received byte before it is classified.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN   = 8,
  parameter int LED_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_fifo_empty,
  input  logic [7:0]           rx_fifo_data_out,
  output logic                 rx_fifo_read_en,
  input  logic                 uart_tx_fifo_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 start_uart_tx,
  output logic [LED_WIDTH-1:0] led_value,
  output logic                 cmd_strobe,
  output logic [7:0]           err_count,
  output logic                 busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);

  state_t               state_reg;
  logic [7:0]           rx_byte_reg;
  logic [7:0]           line_buf_reg [MAX_LEN];
  logic [LEN_W-1:0]     len_reg;
  logic                 overflow_reg;
  logic [7:0]           reply_buf_reg [4];
  reply_len_t           reply_len_reg;
  reply_len_t           reply_idx_reg;
  logic                 read_en_reg;
  logic [7:0]           tx_data_reg;
  logic                 start_tx_reg;
  logic [LED_WIDTH-1:0] led_reg;
  logic                 strobe_reg;
  logic [7:0]           err_count_reg;
`ifdef UART_CMD_ECHO_EN
  logic                 echo_reg;
`endif

  // Codec lane gi decodes argument digit gi and encodes LED nibble gi (MSB first).
  logic [3:0] dec_nibble [2];
  logic       dec_valid  [2];
  logic [3:0] enc_nibble [2];
  logic [7:0] enc_ascii  [2];
  logic [7:0] led_byte;

  assign led_byte      = 8'(led_reg);
  assign enc_nibble[0] = led_byte[7:4];
  assign enc_nibble[1] = led_byte[3:0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_codec
      hex_codec u_codec (
        .ascii_in     (line_buf_reg[gi+1]),
        .nibble_out   (dec_nibble[gi]),
        .nibble_valid (dec_valid[gi]),
        .nibble_in    (enc_nibble[gi]),
        .ascii_out    (enc_ascii[gi])
      );
    end
  endgenerate

  logic [7:0] hex_value;
  logic       hex_ok;
  logic       is_led_cmd;
  logic       is_read_cmd;

  assign hex_value   = {dec_nibble[0], dec_nibble[1]};
  assign hex_ok      = dec_valid[0] && dec_valid[1] &&
                       ((32'(hex_value) >> LED_WIDTH) == 32'd0);
  assign is_led_cmd  = (len_reg == LEN_W'(3)) && (line_buf_reg[0] == CHAR_L) && hex_ok;
  assign is_read_cmd = (len_reg == LEN_W'(1)) && (line_buf_reg[0] == CHAR_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rx_byte_reg   <= '0;
      len_reg       <= '0;
      overflow_reg  <= 1'b0;
      reply_len_reg <= '0;
      reply_idx_reg <= '0;
      read_en_reg   <= 1'b0;
      tx_data_reg   <= '0;
      start_tx_reg  <= 1'b0;
      led_reg       <= '0;
      strobe_reg    <= 1'b0;
      err_count_reg <= '0;
`ifdef UART_CMD_ECHO_EN
      echo_reg      <= 1'b0;
`endif
      for (int i = 0; i < MAX_LEN; i++) line_buf_reg[i] <= '0;
      for (int i = 0; i < 4; i++) reply_buf_reg[i] <= '0;
    end else begin
      read_en_reg  <= 1'b0;
      start_tx_reg <= 1'b0;
      strobe_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_fifo_empty) begin
            rx_byte_reg <= rx_fifo_data_out;
            read_en_reg <= 1'b1;
            state_reg   <= POP;
          end
        end
        POP: begin
`ifdef UART_CMD_ECHO_EN
          state_reg <= (rx_byte_reg == CHAR_LF) ? CLASSIFY : ECHO;
`else
          state_reg <= CLASSIFY;
`endif
        end
`ifdef UART_CMD_ECHO_EN
        ECHO: begin
          // A CR is echoed as CR LF so the terminal moves to a fresh line.
          reply_buf_reg[0] <= rx_byte_reg;
          reply_buf_reg[1] <= CHAR_LF;
          reply_len_reg    <= (rx_byte_reg == CHAR_CR) ? 3'd2 : 3'd1;
          reply_idx_reg    <= '0;
          echo_reg         <= 1'b1;
          state_reg        <= SEND;
        end
`endif
        CLASSIFY: begin
          state_reg <= IDLE;
          if (rx_byte_reg == CHAR_CR) begin
            state_reg <= EXEC;
          end else if (rx_byte_reg != CHAR_LF) begin
            if (len_reg < LEN_W'(MAX_LEN)) begin
              line_buf_reg[len_reg[IDX_W-1:0]] <= rx_byte_reg;
              len_reg <= len_reg + LEN_W'(1);
            end else begin
              overflow_reg <= 1'b1;
            end
          end
        end
        EXEC: begin
          len_reg       <= '0;
          overflow_reg  <= 1'b0;
          reply_idx_reg <= '0;
          reply_len_reg <= 3'd4;
          reply_buf_reg[2] <= CHAR_CR;
          reply_buf_reg[3] <= CHAR_LF;
          state_reg     <= SEND;
          if (!overflow_reg && len_reg == '0) begin
            state_reg <= IDLE;
          end else if (!overflow_reg && is_led_cmd) begin
            led_reg          <= LED_WIDTH'(hex_value);
            strobe_reg       <= 1'b1;
            reply_buf_reg[0] <= CHAR_O;
            reply_buf_reg[1] <= CHAR_K;
          end else if (!overflow_reg && is_read_cmd) begin
            strobe_reg       <= 1'b1;
            reply_buf_reg[0] <= enc_ascii[0];
            reply_buf_reg[1] <= enc_ascii[1];
          end else begin
            reply_buf_reg[0] <= CHAR_E;
            reply_buf_reg[1] <= CHAR_R;
            if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
          end
        end
        SEND: begin
          if (uart_tx_fifo_ready) begin
            tx_data_reg   <= reply_buf_reg[reply_idx_reg[1:0]];
            start_tx_reg  <= 1'b1;
            reply_idx_reg <= reply_idx_reg + 3'd1;
            state_reg     <= GAP;
          end
        end
        GAP: begin
          if (reply_idx_reg < reply_len_reg) begin
            state_reg <= SEND;
`ifdef UART_CMD_ECHO_EN
          end else if (echo_reg) begin
            echo_reg  <= 1'b0;
            state_reg <= CLASSIFY;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_fifo_read_en = read_en_reg;
  assign uart_tx_data    = tx_data_reg;
  assign start_uart_tx   = start_tx_reg;
  assign led_value       = led_reg;
  assign cmd_strobe      = strobe_reg;
  assign err_count       = err_count_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed and random command lines
// checked against a line-level behavioural model (honours UART_CMD_ECHO_EN).
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 8;
  localparam int LED_W   = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_fifo_empty = 1'b1;
  logic [7:0]       rx_fifo_data_out = 8'h00;
  logic             rx_fifo_read_en;
  logic             uart_tx_fifo_ready = 1'b0;
  logic [7:0]       uart_tx_data;
  logic             start_uart_tx;
  logic [LED_W-1:0] led_value;
  logic             cmd_strobe;
  logic [7:0]       err_count;
  logic             busy;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .LED_WIDTH(LED_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx_fifo_empty      (rx_fifo_empty),
    .rx_fifo_data_out   (rx_fifo_data_out),
    .rx_fifo_read_en    (rx_fifo_read_en),
    .uart_tx_fifo_ready (uart_tx_fifo_ready),
    .uart_tx_data       (uart_tx_data),
    .start_uart_tx      (start_uart_tx),
    .led_value          (led_value),
    .cmd_strobe         (cmd_strobe),
    .err_count          (err_count),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  // FIFO models: initial block owns the write side of rx, the monitor owns the rest.
  logic [7:0] rx_mem [4096];
  logic [7:0] tx_mem [4096];
  int rx_wr = 0, rx_rd = 0, tx_wr = 0, tx_rd = 0;
  int n_pops = 0, n_strobes = 0;
  bit rand_ready = 1'b0;
  bit ready_val  = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_fifo_read_en && rx_rd < rx_wr) begin
        rx_rd++;
        n_pops++;
      end
      if (start_uart_tx) begin
        tx_mem[tx_wr % 4096] = uart_tx_data;
        tx_wr++;
      end
      if (cmd_strobe) n_strobes++;
    end
    rx_fifo_empty      <= (rx_rd >= rx_wr);
    rx_fifo_data_out   <= rx_mem[rx_rd % 4096];
    uart_tx_fifo_ready <= rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: works on whole lines and reply strings.
  logic [7:0] mbuf [$];
  logic [7:0] exp_q [$];
  bit movf = 1'b0;
  int mled = 0, merr = 0, mstrobes = 0;

  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexch(input int n);
    string digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  task automatic reply(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic model_exec();
    int v;
    if (!movf && mbuf.size() == 0) return;
    v = (mbuf.size() == 3) ? hexv(mbuf[1]) * 16 + hexv(mbuf[2]) : -1;
    if (!movf && mbuf.size() == 3 && mbuf[0] == "L" && hexv(mbuf[1]) >= 0 &&
        hexv(mbuf[2]) >= 0 && v < (1 << LED_W)) begin
      mled = v;
      mstrobes++;
      reply("O", "K");
    end else if (!movf && mbuf.size() == 1 && mbuf[0] == "R") begin
      mstrobes++;
      reply(hexch(mled / 16), hexch(mled % 16));
    end else begin
      merr = (merr < 255) ? merr + 1 : 255;
      reply("E", "R");
    end
    mbuf.delete();
    movf = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] c);
`ifdef UART_CMD_ECHO_EN
    if (c != 8'h0A) begin
      exp_q.push_back(c);
      if (c == 8'h0D) exp_q.push_back(8'h0A);
    end
`endif
    if (c == 8'h0A) return;
    if (c == 8'h0D) model_exec();
    else if (mbuf.size() < MAX_LEN) mbuf.push_back(c);
    else movf = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] c);
    rx_mem[rx_wr % 4096] = c;
    rx_wr++;
    model_byte(c);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int cyc = 0;
    while (quiet < 3 && cyc < 3000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (rx_rd >= rx_wr && !busy) quiet++;
      else quiet = 0;
    end
    chk({tag, "_timeout"}, 32'(cyc < 3000), 32'd1);
  endtask

  task automatic check_tx(input string tag);
    int n_obs = tx_wr - tx_rd;
    int n_exp = exp_q.size();
    chk({tag, "_len"}, 32'(n_obs), 32'(n_exp));
    for (int i = 0; i < n_obs && i < n_exp; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(tx_mem[(tx_rd + i) % 4096]), 32'(exp_q[i]));
    tx_rd = tx_wr;
    exp_q.delete();
    chk({tag, "_led"}, 32'(led_value), 32'(mled));
    chk({tag, "_err"}, 32'(err_count), 32'(merr));
    chk({tag, "_strobes"}, 32'(n_strobes), 32'(mstrobes));
    $display("txn %-10s tx_bytes=%0d led=%02h err=%0d strobes=%0d",
             tag, n_obs, led_value, err_count, n_strobes);
  endtask

  task automatic send_line(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) push_byte(s[i]);
    push_byte(8'h0D);
    wait_idle(tag);
    check_tx(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},    32'(busy),            32'd0);
    chk({tag, "_led"},     32'(led_value),       32'd0);
    chk({tag, "_err"},     32'(err_count),       32'd0);
    chk({tag, "_start"},   32'(start_uart_tx),   32'd0);
    chk({tag, "_rd_en"},   32'(rx_fifo_read_en), 32'd0);
    chk({tag, "_strobe"},  32'(cmd_strobe),      32'd0);
    chk({tag, "_tx_data"}, 32'(uart_tx_data),    32'd0);
  endtask

  initial begin
    string hexset = "0123456789ABCDEFabcdefG";
    int pops0, pulses0, cyc;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    send_line("L2A", "led2a");
    send_line("R", "read2a");
    send_line("L7F", "range");
    send_line("X", "badcmd");
    send_line("LLLLLLLLLL", "overflow");
    send_line("L01", "led01");
    send_line("", "empty");

    // TX stall: the reply must wait for ready and no further bytes may be popped.
    ready_val = 1'b0;
    repeat (2) @(negedge clk);
    push_byte("L"); push_byte("0"); push_byte("5"); push_byte(8'h0D);
    push_byte("R"); push_byte(8'h0D);
    repeat (40) @(negedge clk);
    #1;
    pops0   = n_pops;
    pulses0 = tx_wr;
    repeat (50) @(negedge clk);
    #1;
    chk("stall_pulses", 32'(tx_wr - pulses0), 32'd0);
    chk("stall_pops",   32'(n_pops - pops0),  32'd0);
    chk("stall_busy",   32'(busy),            32'd1);
`ifdef UART_CMD_ECHO_EN
    chk("stall_pending", 32'(rx_wr - rx_rd), 32'd5);
`else
    chk("stall_pending", 32'(rx_wr - rx_rd), 32'd2);
`endif
    ready_val = 1'b1;
    wait_idle("stall");
    check_tx("stall");

    // Random command lines with a jittering TX ready.
    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int kind = int'($urandom_range(0, 4));
      case (kind)
        0: begin
          push_byte("L");
          push_byte(hexset[$urandom_range(0, 21)]);
          push_byte(hexset[$urandom_range(0, 21)]);
        end
        1: push_byte("R");
        2: ;
        3: for (int j = 0; j < int'($urandom_range(1, 12)); j++)
             push_byte(8'($urandom_range(8'h20, 8'h7E)));
        default: begin
          push_byte("L");
          push_byte(8'h0A);
          push_byte(hexset[$urandom_range(0, 3)]);
          push_byte(hexset[$urandom_range(0, 22)]);
        end
      endcase
      if ($urandom_range(0, 3) == 0) push_byte(8'h0A);
      push_byte(8'h0D);
      wait_idle($sformatf("rand%0d", k));
      check_tx($sformatf("rand%0d", k));
    end
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a reply.
    push_byte("R"); push_byte(8'h0D);
    cyc = 0;
    while (tx_wr - tx_rd < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_wait", 32'(cyc < 500), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
`ifdef UART_CMD_ECHO_EN
    mstrobes--;  // the line had only been echoed, never executed
`endif
    mled = 0;
    merr = 0;
    mbuf.delete();
    movf = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    tx_rd = tx_wr;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    send_line("R", "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
